// File: rtl/uproc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uproc_pkg                                                                |
// | Shared opcode constants, ALU-op and decoder-state encodings of the uProc |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package uproc_pkg;

   localparam logic [7:0] c_INSTR_NOP  = 8'h00;
   localparam logic [7:0] c_INSTR_HLT  = 8'h0F;
   localparam logic [7:0] c_INSTR_LDI  = 8'h80;
   localparam logic [7:0] c_INSTR_ADDI = 8'h90;

   localparam logic [3:0] c_OP_ST  = 4'h1;
   localparam logic [3:0] c_OP_LD  = 4'h2;
   localparam logic [3:0] c_OP_ADD = 4'h3;
   localparam logic [3:0] c_OP_SUB = 4'h4;
   localparam logic [3:0] c_OP_AND = 4'h5;
   localparam logic [3:0] c_OP_OR  = 4'h6;
   localparam logic [3:0] c_OP_XOR = 4'h7;

   typedef enum logic [2:0] {
      ALU_PASSB = 3'd0,
      ALU_ADD   = 3'd1,
      ALU_SUB   = 3'd2,
      ALU_AND   = 3'd3,
      ALU_OR    = 3'd4,
      ALU_XOR   = 3'd5
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_IMM   = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } dec_state_t;

   // ALU operation for the register-operand opcodes (LD passes Rr through)
   function automatic alu_op_t reg_alu_op(input logic [3:0] op);
      alu_op_t v_op;
      case (op)
         c_OP_LD:  v_op = ALU_PASSB;
         c_OP_ADD: v_op = ALU_ADD;
         c_OP_SUB: v_op = ALU_SUB;
         c_OP_AND: v_op = ALU_AND;
         c_OP_OR:  v_op = ALU_OR;
         c_OP_XOR: v_op = ALU_XOR;
         default:  v_op = ALU_PASSB;
      endcase
      return v_op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_dec2to4.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | onehot_dec2to4                                                           |
// | Combinational 2-to-4 one-hot decoder for the register select            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module onehot_dec2to4
(
   input  logic [1:0] sel,
   output logic [3:0] onehot
);

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign onehot[i] = (sel == 2'(i));
   end

endmodule
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_decoder                                                            |
// | Decode stage: valid/ready byte intake, immediate capture, one cycle of   |
// | registered register-file / ALU / accumulator control.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instr_decoder
   import uproc_pkg::*;
(
   input  logic       clk,
   input  logic       Reset,
   input  logic [7:0] Instr,
   input  logic       InstrValid,
   output logic       InstrReady,
   output logic [3:0] RegX,
   output logic       RegCE,
   output logic [2:0] AluOp,
   output logic       AluSrcImm,
   output logic [7:0] Imm,
   output logic       AkuCE,
   output logic       Illegal,
   output logic       Halted
);

   dec_state_t r_state, w_state_nxt;
   logic [3:0] r_regx, w_regx;
   logic       r_regce, w_regce;
   alu_op_t    r_aluop, w_aluop;
   logic       r_srcimm, w_srcimm;
   logic       r_akuce, w_akuce;
   logic       r_illegal, w_illegal;
   logic       r_halted;
   logic [7:0] r_imm, w_imm;
   logic       r_is_addi, w_is_addi;

   logic [3:0] w_onehot;
   logic [3:0] w_opcode;
   logic       w_regop_ok;

   assign w_opcode   = Instr[7:4];
   // opcodes 1..7 are register ops and need Instr[3:2] == 0
   assign w_regop_ok = !Instr[7] && (Instr[6:4] != 3'd0) && (Instr[3:2] == 2'b00);

   onehot_dec2to4 u_regsel (
      .sel    (Instr[1:0]),
      .onehot (w_onehot)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_regx      = 4'b0000;
      w_regce     = 1'b0;
      w_aluop     = ALU_PASSB;
      w_srcimm    = 1'b0;
      w_akuce     = 1'b0;
      w_illegal   = 1'b0;
      w_imm       = r_imm;
      w_is_addi   = r_is_addi;
      case (r_state)
         ST_FETCH: begin
            if (InstrValid) begin
               w_state_nxt = ST_EXEC;
               if (Instr == c_INSTR_HLT) begin
                  w_state_nxt = ST_HALT;
               end else if (Instr == c_INSTR_LDI || Instr == c_INSTR_ADDI) begin
                  w_state_nxt = ST_IMM;
                  w_is_addi   = (Instr == c_INSTR_ADDI);
               end else if (w_regop_ok) begin
                  w_regx = w_onehot;
                  if (w_opcode == c_OP_ST) begin
                     w_regce = 1'b1;
                  end else begin
                     w_akuce = 1'b1;
                     w_aluop = reg_alu_op(w_opcode);
                  end
               end else if (Instr != c_INSTR_NOP) begin
                  w_illegal = 1'b1;
               end
            end
         end
         ST_IMM: begin
            if (InstrValid) begin
               w_state_nxt = ST_EXEC;
               w_imm       = Instr;
               w_srcimm    = 1'b1;
               w_akuce     = 1'b1;
               w_aluop     = r_is_addi ? ALU_ADD : ALU_PASSB;
            end
         end
         ST_EXEC: w_state_nxt = ST_FETCH;
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= ST_FETCH;
         r_regx    <= 4'b0000;
         r_regce   <= 1'b0;
         r_aluop   <= ALU_PASSB;
         r_srcimm  <= 1'b0;
         r_akuce   <= 1'b0;
         r_illegal <= 1'b0;
         r_halted  <= 1'b0;
         r_imm     <= 8'h00;
         r_is_addi <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_regx    <= w_regx;
         r_regce   <= w_regce;
         r_aluop   <= w_aluop;
         r_srcimm  <= w_srcimm;
         r_akuce   <= w_akuce;
         r_illegal <= w_illegal;
         r_halted  <= (w_state_nxt == ST_HALT);
         r_imm     <= w_imm;
         r_is_addi <= w_is_addi;
      end
   end

   assign InstrReady = (r_state == ST_FETCH) || (r_state == ST_IMM);
   assign RegX       = r_regx;
   assign RegCE      = r_regce;
   assign AluOp      = r_aluop;
   assign AluSrcImm  = r_srcimm;
   assign Imm        = r_imm;
   assign AkuCE      = r_akuce;
   assign Illegal    = r_illegal;
   assign Halted     = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_decoder                                                         |
// | Directed self-checking bench for instr_decoder                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_decoder;

   logic       clk;
   logic       Reset;
   logic [7:0] Instr;
   logic       InstrValid;
   logic       InstrReady;
   logic [3:0] RegX;
   logic       RegCE;
   logic [2:0] AluOp;
   logic       AluSrcImm;
   logic [7:0] Imm;
   logic       AkuCE;
   logic       Illegal;
   logic       Halted;

   int n_checks = 0;
   int n_errors = 0;

   instr_decoder dut (
      .clk        (clk),
      .Reset      (Reset),
      .Instr      (Instr),
      .InstrValid (InstrValid),
      .InstrReady (InstrReady),
      .RegX       (RegX),
      .RegCE      (RegCE),
      .AluOp      (AluOp),
      .AluSrcImm  (AluSrcImm),
      .Imm        (Imm),
      .AkuCE      (AkuCE),
      .Illegal    (Illegal),
      .Halted     (Halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {RegX, RegCE, AluOp, AluSrcImm, AkuCE, Illegal, Halted, InstrReady}
   function automatic logic [12:0] ctl(input logic [3:0] rx, input logic rce,
                                       input logic [2:0] op, input logic si,
                                       input logic ace, input logic il,
                                       input logic h, input logic rdy);
      return {rx, rce, op, si, ace, il, h, rdy};
   endfunction

   logic [12:0] obs_ctl;
   assign obs_ctl = {RegX, RegCE, AluOp, AluSrcImm, AkuCE, Illegal, Halted, InstrReady};

   localparam logic [12:0] c_IDLE = 13'b0000_0_000_0_0_0_0_1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one-byte instruction: its EXEC cycle, then back to FETCH
   task automatic run1(input string tag, input logic [7:0] b, input logic [12:0] exp);
      Instr      = b;
      InstrValid = 1'b1;
      tick();
      InstrValid = 1'b0;
      Instr      = 8'h00;
      chk(tag, 16'(obs_ctl), 16'(exp));
      tick();
      chk({tag, "_after"}, 16'(obs_ctl), 16'(c_IDLE));
   endtask

   task automatic run2(input string tag, input logic [7:0] op, input int gap,
                       input logic [7:0] imm, input logic [12:0] exp);
      Instr      = op;
      InstrValid = 1'b1;
      tick();
      InstrValid = 1'b0;
      Instr      = 8'hEE;
      chk({tag, "_imm"}, 16'(obs_ctl), 16'(c_IDLE));
      for (int i = 0; i < gap; i++) begin
         tick();
         chk({tag, "_gap"}, 16'(obs_ctl), 16'(c_IDLE));
      end
      Instr      = imm;
      InstrValid = 1'b1;
      tick();
      InstrValid = 1'b0;
      chk({tag, "_exec"}, 16'(obs_ctl), 16'(exp));
      chk({tag, "_immval"}, 16'(Imm), 16'(imm));
      tick();
      chk({tag, "_after"}, 16'(obs_ctl), 16'(c_IDLE));
      chk({tag, "_immhold"}, 16'(Imm), 16'(imm));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      Reset      = 1'b1;
      Instr      = 8'h00;
      InstrValid = 1'b0;
      repeat (3) @(posedge clk);
      #1 Reset = 1'b0;
      chk("reset_ctl", 16'(obs_ctl), 16'(c_IDLE));
      chk("reset_imm", 16'(Imm), 16'h0000);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_hold", 16'(obs_ctl), 16'(c_IDLE));
      end

      run1("st_r2",  8'h12, ctl(4'b0100, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      run1("add_r3", 8'h33, ctl(4'b1000, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      run1("xor_r0", 8'h70, ctl(4'b0001, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      run1("ld_r1",  8'h21, ctl(4'b0010, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      run1("sub_r1", 8'h41, ctl(4'b0010, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      run1("and_r2", 8'h52, ctl(4'b0100, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      run1("or_r3",  8'h63, ctl(4'b1000, 1'b0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      run1("nop",    8'h00, ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      run1("ill_b0", 8'hB0, ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      run1("ill_34", 8'h34, ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      run1("ill_81", 8'h81, ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      run1("ill_05", 8'h05, ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
      run1("ill_1c", 8'h1C, ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

      run2("ldi",  8'h80, 3, 8'hA5, ctl(4'b0000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      run2("addi", 8'h90, 0, 8'h3C, ctl(4'b0000, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

      // reset in EXEC clears controls without waiting for a clock edge
      Instr      = 8'h33;
      InstrValid = 1'b1;
      tick();
      InstrValid = 1'b0;
      Reset      = 1'b1;
      #1;
      chk("rst_exec_ctl", 16'(obs_ctl), 16'(c_IDLE));
      chk("rst_exec_imm", 16'(Imm), 16'h0000);
      #1 Reset = 1'b0;

      Instr      = 8'h0F;
      InstrValid = 1'b1;
      tick();
      Instr      = 8'h12;
      chk("hlt", 16'(obs_ctl), 16'(ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hlt_hold", 16'(obs_ctl),
             16'(ctl(4'b0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
      end
      InstrValid = 1'b0;
      Reset      = 1'b1;
      #1;
      chk("hlt_reset", 16'(obs_ctl), 16'(c_IDLE));
      #1 Reset = 1'b0;

      // ADDI abandoned in IMM by reset
      Instr      = 8'h90;
      InstrValid = 1'b1;
      tick();
      InstrValid = 1'b0;
      chk("addi_pend", 16'(obs_ctl), 16'(c_IDLE));
      Reset = 1'b1;
      #1;
      chk("rst_imm_ctl", 16'(obs_ctl), 16'(c_IDLE));
      chk("rst_imm_imm", 16'(Imm), 16'h0000);
      #1 Reset = 1'b0;
      tick();
      chk("post_rst_idle", 16'(obs_ctl), 16'(c_IDLE));
      run1("st_r2_again", 8'h12, ctl(4'b0100, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_decoder.md
# instr_decoder

Instruction decode stage of the 8-bit uProcessor. It accepts instruction bytes from the fetch side through a valid/ready handshake, collects a trailing immediate byte for two-byte instructions, and drives one cycle of registered control into the downstream register file, ALU and accumulator. Its outputs are the register file's one-hot register select (`RegX`) and write enable (`RegCE`), plus ALU and accumulator control.

## Interface
Parameters
- none; opcode and ALU-op encodings come from the shared package.

Ports
- `clk`  in  1  single clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Instr`  in  8  instruction or immediate byte from fetch.
- `InstrValid`  in  1  `Instr` is valid this cycle.
- `InstrReady`  out  1  decoder accepts `Instr` this cycle; a transfer happens when `InstrValid & InstrReady`.
- `RegX`  out  4  one-hot register select (bit n = Rn) into the register file; 0 = none.
- `RegCE`  out  1  register write enable; writes Aku into the selected register.
- `AluOp`  out  3  ALU operation: PASSB=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5.
- `AluSrcImm`  out  1  ALU B operand is `Imm`, not the register-file output.
- `Imm`  out  8  latched immediate byte.
- `AkuCE`  out  1  accumulator load enable.
- `Illegal`  out  1  one-cycle pulse: an undefined opcode was decoded.
- `Halted`  out  1  core is halted.

## Operation
- Encoding: `Instr[7:4]` is the opcode; `Instr[1:0]` is the register r; `Instr[3:2]` must be 0 for register ops.
  - 0x00 NOP.
  - 0x0F HLT.
  - 0x1r ST: Rr <- Aku.
  - 0x2r LD: Aku <- Rr (PASSB).
  - 0x3r ADD, 0x4r SUB, 0x5r AND, 0x6r OR, 0x7r XOR: Aku <- Aku op Rr.
  - 0x80 LDI and 0x90 ADDI: two-byte instructions; the next byte is the immediate.
- Everything else is illegal: encodings 0x01–0x0E, 0xA0–0xFF, a nonzero `Instr[3:2]` in a register op, and a nonzero low nibble on LDI/ADDI.
- States:
  - FETCH: `InstrReady`=1. On transfer, decode the byte:
    - LDI/ADDI go to IMM.
    - HLT goes to HALT.
    - Everything else goes to EXEC.
  - IMM: `InstrReady`=1. On transfer, latch `Imm` and go to EXEC.
  - EXEC: `InstrReady`=0. Control outputs are driven for exactly this one cycle, then the state returns to FETCH.
  - HALT: `InstrReady`=0 and `Halted`=1. Only `Reset` leaves HALT.
- Control values in EXEC:
  - ST: `RegX`=onehot(r), `RegCE`=1, `AkuCE`=0.
  - LD/ALU ops: `RegX`=onehot(r), `RegCE`=0, `AkuCE`=1, `AluOp` per opcode.
  - LDI: `AluSrcImm`=1, `AluOp`=PASSB, `AkuCE`=1, `RegX`=0.
  - ADDI: as LDI but `AluOp`=ADD.
  - NOP and illegal: all enables 0, `RegX`=0. An illegal opcode also raises `Illegal`=1.
- Outside EXEC: `RegX`, `RegCE`, `AkuCE`, `AluSrcImm` and `Illegal` are 0, and `AluOp`=PASSB. `Imm` holds its last value.
- `RegX` and `RegCE` are never asserted together with `AkuCE`.

## Timing
- Reset (asynchronous, active-high):
  - State goes to FETCH.
  - All outputs go to 0, except `InstrReady`, which is 1 once `Reset` deasserts.
  - `Imm` resets to 0x00.
- Every control output is registered, with no combinational path from `Instr` to control outputs. `InstrReady` is a decode of the state register only.
- Latency:
  - One-byte instruction: transfer at edge N, controls valid for the cycle after edge N.
  - Two-byte instruction: controls valid for the cycle after the immediate transfer.
- Throughput is at most one instruction per 2 cycles (FETCH, EXEC).
- `InstrValid` low in FETCH or IMM: the decoder waits indefinitely and outputs stay idle. A bubble between the opcode and immediate bytes is allowed.
- `Reset` asserted during IMM or EXEC: the pending instruction is discarded and its controls are cleared immediately (asynchronously).
- The register file samples `RegCE` at the edge that ends EXEC.

## Structure
- Shared package `uproc_pkg` holds:
  - the opcode constants;
  - the `alu_op_t` enum (PASSB, ADD, SUB, AND, OR, XOR);
  - the `dec_state_t` enum (FETCH, IMM, EXEC, HALT).
- The ALU also imports `uproc_pkg`.
- One sub-module, `onehot_dec2to4`, is natural: a combinational 2-to-4 decoder producing `RegX` from r.
- The FSM and output registers live in `instr_decoder`.

## Test plan
- Reset, then with `InstrValid`=0: `InstrReady`=1, all controls 0, `Imm`=0x00. Holding 20 cycles causes no change.
- ST R2 (0x12): exactly one EXEC cycle with `RegX`=4'b0100, `RegCE`=1, `AkuCE`=0. `InstrReady`=0 in that cycle and returns to 1 on the next.
- ADD R3 (0x33): `RegX`=4'b1000, `AkuCE`=1, `AluOp`=ADD, `RegCE`=0. XOR R0 (0x70): `RegX`=4'b0001, `AluOp`=XOR.
- LDI 0xA5 (0x80, 3 idle cycles, 0xA5): no controls during the gap. EXEC shows `Imm`=0xA5, `AluSrcImm`=1, `AluOp`=PASSB, `AkuCE`=1, `RegX`=0.
- Illegal bytes 0xB0, 0x34 and 0x81: each gives a one-cycle `Illegal` pulse with all enables 0, and the decoder resumes at FETCH.
- HLT (0x0F): `Halted`=1 and `InstrReady`=0 persist while 0x12 is offered. `Reset` asserted during the IMM of a pending ADDI clears everything, and the next 0x12 decodes normally.
